// File: rtl/shift_rmw_ctrl_if.sv
// Memory bus between the shift/rotate RMW controller and its memory port.
// master = controller side, slave = memory side.
interface shift_rmw_ctrl_if;
  logic [15:0] o_addr;
  logic        o_rd;
  logic        o_wr;
  logic [7:0]  o_wdata;
  logic [7:0]  i_rdata;
  logic        i_ready;

  modport master (
    output o_addr, o_rd, o_wr, o_wdata,
    input  i_rdata, i_ready
  );

  modport slave (
    input  o_addr, o_rd, o_wr, o_wdata,
    output i_rdata, i_ready
  );
endinterface

// File: rtl/shift_rmw_ctrl.sv
// 6502-style shift/rotate sequencer: accumulator or memory read-modify-write
// with dummy write, driving an external combinational shifter.
module shift_rmw_ctrl (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_start,
  input  logic [1:0]  i_op,
  input  logic        i_acc_mode,
  input  logic [15:0] i_addr,
  input  logic [7:0]  i_acc,
  input  logic        i_c,
  shift_rmw_ctrl_if.master mem,
  output logic [7:0]  o_sh_data,
  output logic        o_sh_rotate,
  output logic        o_sh_right,
  output logic        o_sh_c,
  input  logic [7:0]  i_sh_data,
  input  logic        i_sh_n,
  input  logic        i_sh_z,
  input  logic        i_sh_c,
  output logic [7:0]  o_result,
  output logic        o_n,
  output logic        o_z,
  output logic        o_c,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_acc_we,
  output logic        o_flag_we
);

  typedef enum logic [2:0] {
    IDLE, READ, DUMMY, WRITE, ACC, DONE
  } state_t;

  state_t     state;
  logic [1:0] op;
  logic       carry;
  logic       acc_mode;
  logic [7:0] operand;
  logic       first;

  assign o_sh_data   = operand;
  assign o_sh_rotate = op[1];
  assign o_sh_right  = op[0];
  assign o_sh_c      = carry;
  assign o_busy      = (state != IDLE);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state       <= IDLE;
      op          <= '0;
      carry       <= 1'b0;
      acc_mode    <= 1'b0;
      operand     <= '0;
      first       <= 1'b0;
      mem.o_addr  <= '0;
      mem.o_rd    <= 1'b0;
      mem.o_wr    <= 1'b0;
      mem.o_wdata <= '0;
      o_result    <= '0;
      o_n         <= 1'b0;
      o_z         <= 1'b0;
      o_c         <= 1'b0;
      o_done      <= 1'b0;
      o_acc_we    <= 1'b0;
      o_flag_we   <= 1'b0;
    end else begin
      o_done    <= 1'b0;
      o_acc_we  <= 1'b0;
      o_flag_we <= 1'b0;
      unique case (state)
        IDLE: begin
          if (i_start) begin
            op         <= i_op;
            carry      <= i_c;
            acc_mode   <= i_acc_mode;
            mem.o_addr <= i_addr;
            if (i_acc_mode) begin
              operand <= i_acc;
              state   <= ACC;
            end else begin
              mem.o_rd <= 1'b1;
              state    <= READ;
            end
          end
        end
        READ: begin
          if (mem.i_ready) begin
            operand     <= mem.i_rdata;
            mem.o_wdata <= mem.i_rdata;
            mem.o_rd    <= 1'b0;
            mem.o_wr    <= 1'b1;
            first       <= 1'b1;
            state       <= DUMMY;
          end
        end
        DUMMY: begin
          // Shifter result is captured once; stalls reuse the stored copy.
          first <= 1'b0;
          if (first) begin
            o_result <= i_sh_data;
            o_n      <= i_sh_n;
            o_z      <= i_sh_z;
            o_c      <= i_sh_c;
          end
          if (mem.i_ready) begin
            mem.o_wdata <= first ? i_sh_data : o_result;
            state       <= WRITE;
          end
        end
        WRITE: begin
          if (mem.i_ready) begin
            mem.o_wr  <= 1'b0;
            o_done    <= 1'b1;
            o_flag_we <= 1'b1;
            o_acc_we  <= acc_mode;
            state     <= DONE;
          end
        end
        ACC: begin
          o_result  <= i_sh_data;
          o_n       <= i_sh_n;
          o_z       <= i_sh_z;
          o_c       <= i_sh_c;
          o_done    <= 1'b1;
          o_flag_we <= 1'b1;
          o_acc_we  <= acc_mode;
          state     <= DONE;
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/shift_rmw_ctrl.md
SHIFT_RMW_CTRL -- requirements
Module: shift_rmw_ctrl

Interface
REQ-001 The block SHALL have one clock, and its reset SHALL be asynchronous and active-low.
REQ-002 i_clk  input  1  clock; all state updates on rising edge.
REQ-003 i_rst_n  input  1  asynchronous active-low reset.
REQ-004 i_start  input  1  request to begin one shift/rotate operation.
REQ-005 i_op  input  2  operation: 00 ASL, 01 LSR, 10 ROL, 11 ROR.
REQ-006 i_acc_mode  input  1  1 = operand is i_acc; 0 = operand is memory at i_addr.
REQ-007 i_addr  input  16  memory operand address.
REQ-008 i_acc  input  8  accumulator operand value.
REQ-009 i_c  input  1  carry flag in.
REQ-010 o_addr  output  16  memory address.
REQ-011 o_rd  output  1  memory read strobe.
REQ-012 o_wr  output  1  memory write strobe.
REQ-013 o_wdata  output  8  memory write data.
REQ-014 i_rdata  input  8  memory read data; valid when i_ready=1.
REQ-015 i_ready  input  1  memory access completes this cycle.
REQ-016 o_sh_data, o_sh_rotate, o_sh_right, o_sh_c  output  8/1/1/1  drive the shifter datapath.
REQ-017 i_sh_data, i_sh_n, i_sh_z, i_sh_c  input  8/1/1/1  shifter result and flags (combinational return).
REQ-018 o_result, o_n, o_z, o_c  output  8/1/1/1  registered result and flags.
REQ-019 o_busy, o_done, o_acc_we, o_flag_we  output  1 each  status: busy, 1-cycle completion pulse, accumulator write-enable, flag write-enable.

Function
REQ-020 States SHALL be IDLE, READ, DUMMY, WRITE, ACC, DONE.
REQ-021 IDLE: i_start=1 SHALL latch i_op, i_addr, i_c, i_acc, i_acc_mode; next state ACC if i_acc_mode=1, else READ.
REQ-022 READ: o_rd=1 and o_addr=latched address; on i_ready=1, i_rdata SHALL load the operand register and the state SHALL go to DUMMY; otherwise READ SHALL hold with o_addr stable.
REQ-023 DUMMY: o_wr=1 with o_wdata=unmodified operand (6502 RMW dummy write); on the first DUMMY cycle, i_sh_data/n/z/c SHALL load o_result/o_n/o_z/o_c; on i_ready=1, next state WRITE.
REQ-024 WRITE: o_wr=1 with o_wdata=o_result and o_addr=latched address; on i_ready=1, next state DONE.
REQ-025 ACC: operand register=latched i_acc; the shifter result and flags SHALL be captured into o_result/o_n/o_z/o_c; next state DONE unconditionally.
REQ-026 DONE: o_done=1, o_flag_we=1, o_acc_we=latched acc_mode for exactly one cycle; next state IDLE.
REQ-027 Shifter drive SHALL be combinational from registers: o_sh_data=operand, o_sh_rotate=op[1], o_sh_right=op[0], o_sh_c=latched carry.
REQ-028 o_busy SHALL be 1 in every state except IDLE.
REQ-029 i_start SHALL be ignored in every state except IDLE, including DONE; latched operands SHALL not change while busy.
REQ-030 o_rd and o_wr SHALL never both be 1; both SHALL be 0 in IDLE, ACC, and DONE.
REQ-031 Latency with i_ready held at 1: memory mode SHALL reach DONE 4 cycles after the i_start edge; accumulator mode SHALL reach DONE 2 cycles after it.
REQ-032 Each low i_ready cycle in READ, DUMMY, or WRITE SHALL add exactly one cycle of latency.
REQ-033 o_result, o_n, o_z, o_c SHALL hold their values from the last capture until the next capture.

Reset
REQ-034 i_rst_n=0 SHALL force state IDLE immediately, regardless of the clock.
REQ-035 i_rst_n=0 SHALL force all outputs and internal registers to 0 immediately, regardless of the clock.
REQ-036 Reset asserted mid-operation SHALL drop o_rd/o_wr at once and produce no o_done; operation resumes only on a new i_start after reset release.

Verification
REQ-037 ACC ASL: i_acc=0x81, i_c=0 -> o_result=0x02, c=1, n=0, z=0; o_done and o_acc_we high at cycle 2.
REQ-038 Memory ROR, i_addr=0x1234, i_rdata=0x01, i_c=1, i_ready=1 -> read 0x1234; write 0x01; write 0x80; c=1, n=1; o_done at cycle 4; o_acc_we=0.
REQ-039 Memory LSR, i_rdata=0x01, i_c=0 -> written value 0x00, z=1, c=1, n=0.
REQ-040 i_ready low for 3 cycles in READ -> o_rd and o_addr held stable; o_done at cycle 7.
REQ-041 i_rst_n pulsed low during WRITE -> o_wr=0 the same cycle, o_busy=0, no o_done pulse.
REQ-042 i_start held high throughout an operation -> no relatch and no restart until IDLE; exactly one o_done per accepted start.
